// File: rtl/cordic_atan2.sv
// cordic_atan2: iterative CORDIC vectoring engine (sin/cos pair -> phase).
// Input  : AXI-stream {sin, cos}, both signed IN_DW bits.
// Output : AXI-stream unsigned phase, 0..2^PHASE_DW-1 covering 0..2*pi.
// Optional feature macro DDS_ATAN_MAG_EN adds m_axis_mag_tdata (final CORDIC
// x, gain not compensated) which shares the phase handshake.
module cordic_atan2 #(
    parameter int IN_DW      = 16,
    parameter int PHASE_DW   = 16,
    parameter int ITERATIONS = 14
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2*IN_DW-1:0]    s_axis_in_tdata,
    input  logic                  s_axis_in_tvalid,
    output logic                  s_axis_in_tready,
    output logic [PHASE_DW-1:0]   m_axis_phase_tdata,
    output logic                  m_axis_phase_tvalid,
    input  logic                  m_axis_phase_tready
`ifdef DDS_ATAN_MAG_EN
    ,
    output logic [IN_DW+1:0]      m_axis_mag_tdata
`endif
);

    // Two guard bits: one absorbs negation of the most negative input,
    // the other absorbs the CORDIC gain (~1.647 * sqrt(2)).
    localparam int XW    = IN_DW + 2;
    localparam int CNT_W = $clog2(ITERATIONS);
    localparam int TAB_N = 1 << CNT_W;
    localparam real PI   = 3.14159265358979323846;
    localparam logic [PHASE_DW-1:0] Z_HALF = {1'b1, {(PHASE_DW-1){1'b0}}};
    localparam logic [CNT_W-1:0]    ITER_LAST = CNT_W'(ITERATIONS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROTATE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Elaboration-time arctangent table entry: round(atan(2^-idx) * 2^PHASE_DW / (2*pi)).
    // The Maclaurin series converges quickly for idx >= 1 (t <= 0.5); idx 0 is exactly pi/4.
    function automatic logic [PHASE_DW-1:0] atan_entry(input int idx);
        real t;
        real term;
        real sum;
        real scale;
        t = 1.0;
        for (int k = 0; k < idx; k++) begin
            t = t * 0.5;
        end
        if (idx == 0) begin
            sum = PI / 4.0;
        end else begin
            sum  = 0.0;
            term = t;
            for (int k = 0; k < 40; k++) begin
                if ((k % 2) == 0) begin
                    sum = sum + term / real'(2 * k + 1);
                end else begin
                    sum = sum - term / real'(2 * k + 1);
                end
                term = term * t * t;
            end
        end
        scale = 1.0;
        for (int k = 0; k < PHASE_DW; k++) begin
            scale = scale * 2.0;
        end
        return PHASE_DW'($rtoi(sum * scale / (2.0 * PI) + 0.5));
    endfunction

    logic [PHASE_DW-1:0] atan_tab [TAB_N];

    for (genvar g = 0; g < TAB_N; g++) begin : g_atan
        localparam logic [PHASE_DW-1:0] A_G = (g < ITERATIONS) ? atan_entry(g) : '0;
        assign atan_tab[g] = A_G;
    end

    state_t                     state_r;
    state_t                     state_nxt_s;
    logic [CNT_W-1:0]           iter_r;
    logic signed [XW-1:0]       x_r;
    logic signed [XW-1:0]       y_r;
    logic [PHASE_DW-1:0]        z_r;
    logic                       zero_r;

    logic signed [IN_DW-1:0]    sin_s;
    logic signed [IN_DW-1:0]    cos_s;
    logic signed [XW-1:0]       sin_ext_s;
    logic signed [XW-1:0]       cos_ext_s;
    logic signed [XW-1:0]       x_cap_s;
    logic signed [XW-1:0]       y_cap_s;
    logic [PHASE_DW-1:0]        z_cap_s;
    logic signed [XW-1:0]       x_sh_s;
    logic signed [XW-1:0]       y_sh_s;
    logic signed [XW-1:0]       x_rot_s;
    logic signed [XW-1:0]       y_rot_s;
    logic [PHASE_DW-1:0]        z_rot_s;
    logic                       accept_s;
    logic                       last_s;
    logic                       ready_nxt_s;
    logic                       valid_nxt_s;

    assign sin_s     = $signed(s_axis_in_tdata[2*IN_DW-1:IN_DW]);
    assign cos_s     = $signed(s_axis_in_tdata[IN_DW-1:0]);
    assign sin_ext_s = {{2{sin_s[IN_DW-1]}}, sin_s};
    assign cos_ext_s = {{2{cos_s[IN_DW-1]}}, cos_s};
    assign accept_s  = (state_r == ST_IDLE) && s_axis_in_tvalid && s_axis_in_tready;
    assign last_s    = (state_r == ST_ROTATE) && (iter_r == ITER_LAST);
    assign x_sh_s    = x_r >>> iter_r;
    assign y_sh_s    = y_r >>> iter_r;

    // Pre-rotation: fold the left half-plane onto the right one by adding pi.
    always_comb begin
        if (cos_ext_s[XW-1]) begin
            x_cap_s = -cos_ext_s;
            y_cap_s = -sin_ext_s;
            z_cap_s = Z_HALF;
        end else begin
            x_cap_s = cos_ext_s;
            y_cap_s = sin_ext_s;
            z_cap_s = '0;
        end
    end

    // One micro-rotation driving y toward zero; x and y use pre-update values.
    always_comb begin
        if (!y_r[XW-1]) begin
            x_rot_s = x_r + y_sh_s;
            y_rot_s = y_r - x_sh_s;
            z_rot_s = z_r + atan_tab[iter_r];
        end else begin
            x_rot_s = x_r - y_sh_s;
            y_rot_s = y_r + x_sh_s;
            z_rot_s = z_r - atan_tab[iter_r];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_ROTATE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ROTATE: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_ROTATE;
                end
            end
            ST_DONE: begin
                if (m_axis_phase_tready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM output decode from the next state, so the handshake flags are registered.
    always_comb begin
        ready_nxt_s = 1'b0;
        valid_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_IDLE:   ready_nxt_s = 1'b1;
            ST_ROTATE: ready_nxt_s = 1'b0;
            ST_DONE:   valid_nxt_s = 1'b1;
            default: begin
                ready_nxt_s = 1'b0;
                valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Handshake flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_axis_in_tready    <= 1'b0;
            m_axis_phase_tvalid <= 1'b0;
        end else begin
            s_axis_in_tready    <= ready_nxt_s;
            m_axis_phase_tvalid <= valid_nxt_s;
        end
    end

    // CORDIC datapath: capture with pre-rotation, then one iteration per cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_r    <= '0;
            y_r    <= '0;
            z_r    <= '0;
            iter_r <= '0;
            zero_r <= 1'b0;
        end else if (accept_s) begin
            x_r    <= x_cap_s;
            y_r    <= y_cap_s;
            z_r    <= z_cap_s;
            iter_r <= '0;
            zero_r <= (sin_s == '0) && (cos_s == '0);
        end else if (state_r == ST_ROTATE) begin
            x_r <= x_rot_s;
            y_r <= y_rot_s;
            z_r <= z_rot_s;
            if (last_s) begin
                iter_r <= '0;
            end else begin
                iter_r <= iter_r + CNT_W'(1);
            end
        end else begin
            x_r    <= x_r;
            y_r    <= y_r;
            z_r    <= z_r;
            iter_r <= iter_r;
        end
    end

    // Result register: loaded with the last iteration, held until the next result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_axis_phase_tdata <= '0;
        end else if (last_s) begin
            m_axis_phase_tdata <= zero_r ? '0 : z_rot_s;
        end else begin
            m_axis_phase_tdata <= m_axis_phase_tdata;
        end
    end

`ifdef DDS_ATAN_MAG_EN
    // Magnitude register: final x, loaded alongside the phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_axis_mag_tdata <= '0;
        end else if (last_s) begin
            m_axis_mag_tdata <= zero_r ? '0 : $unsigned(x_rot_s);
        end else begin
            m_axis_mag_tdata <= m_axis_mag_tdata;
        end
    end
`endif

endmodule

// File: tb/tb_cordic_atan2.sv
// Self-checking bench for cordic_atan2. Expected phases come from real-valued
// atan2 of the applied sample; magnitudes from 1.64676 * amplitude.
module tb_cordic_atan2;

    localparam int  IN_DW      = 16;
    localparam int  PHASE_DW   = 16;
    localparam int  ITERATIONS = 14;
    localparam real PI         = 3.14159265358979323846;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic [2*IN_DW-1:0]    s_tdata = '0;
    logic                  s_tvalid = 1'b0;
    logic                  s_tready;
    logic [PHASE_DW-1:0]   m_phase;
    logic                  m_valid;
    logic                  m_ready = 1'b0;
`ifdef DDS_ATAN_MAG_EN
    logic [IN_DW+1:0]      m_mag;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_q[$];
    int out_q[$];
    int out_cyc_q[$];

    cordic_atan2 #(.IN_DW(IN_DW), .PHASE_DW(PHASE_DW), .ITERATIONS(ITERATIONS)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .s_axis_in_tdata     (s_tdata),
        .s_axis_in_tvalid    (s_tvalid),
        .s_axis_in_tready    (s_tready),
        .m_axis_phase_tdata  (m_phase),
        .m_axis_phase_tvalid (m_valid),
        .m_axis_phase_tready (m_ready)
`ifdef DDS_ATAN_MAG_EN
        ,
        .m_axis_mag_tdata    (m_mag)
`endif
    );

    always #5 clk = ~clk;

    // Cycle counter plus logs of input accepts and output handshakes.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset_n && s_tvalid && s_tready) acc_q.push_back(cyc + 1);
        if (reset_n && m_valid && m_ready) begin
            out_q.push_back(int'(m_phase));
            out_cyc_q.push_back(cyc + 1);
        end
    end

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        else return -$rtoi(-x + 0.5);
    endfunction

    function automatic int model_phase(input int s, input int c);
        real p;
        int  r;
        if (s == 0 && c == 0) return 0;
        p = $atan2(real'(s), real'(c)) * 65536.0 / (2.0 * PI);
        if (p < 0.0) p = p + 65536.0;
        r = $rtoi(p + 0.5);
        return r % 65536;
    endfunction

    function automatic int model_mag(input int s, input int c);
        return rnd(1.646760258 * $sqrt(real'(s) * real'(s) + real'(c) * real'(c)));
    endfunction

    function automatic int circ_err(input int a, input int b);
        int d;
        d = (a - b) & 32'h0000FFFF;
        if (d > 32767) d = 65536 - d;
        return d;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input int obs, input int exp, input int tol);
        n_vec++;
        assert (circ_err(obs, exp) <= tol) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d +/-%0d", tag, obs, exp, tol);
        end
    endtask

    task automatic chk_near(input string tag, input int obs, input int exp, input int tol);
        int d;
        d = (obs > exp) ? obs - exp : exp - obs;
        n_vec++;
        assert (d <= tol) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d +/-%0d", tag, obs, exp, tol);
        end
    endtask

    // Wait (on falling edges) until n accepts have been logged.
    task automatic wait_acc(input int n);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 400 && !got; k++) begin
            if (acc_q.size() >= n) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) chk("accept_timeout", 0, 1);
    endtask

    task automatic drive_accept(input int s, input int c);
        int base;
        base = acc_q.size();
        @(negedge clk);
        s_tdata  = {16'(s), 16'(c)};
        s_tvalid = 1'b1;
        wait_acc(base + 1);
        s_tvalid = 1'b0;
    endtask

    // Wait for the result of the last accepted sample, check it, optionally
    // stall the consumer, then complete the handshake.
    task automatic collect(input int exp_ph, input int tol, input int exp_mag,
                           input int mag_tol, input int stall, input bit chk_lat);
        bit got;
        bit stable;
        int lat;
        int ph;
        int n_out;
        got    = 1'b0;
        stable = 1'b1;
        for (int k = 0; k < 100 && !got; k++) begin
            if (m_valid === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) begin
            chk("valid_timeout", 0, 1);
        end else begin
            // +1 counts the accept cycle itself.
            lat = cyc - acc_q[$] + 1;
            if (chk_lat) chk("latency", lat, ITERATIONS + 1);
            ph = int'(m_phase);
            chk_tol("phase", ph, exp_ph, tol);
`ifdef DDS_ATAN_MAG_EN
            chk_near("mag", int'(m_mag), exp_mag, mag_tol);
`endif
            for (int k = 0; k < stall; k++) begin
                @(negedge clk);
                if (int'(m_phase) != ph || m_valid !== 1'b1 || s_tready !== 1'b0) stable = 1'b0;
            end
            if (stall > 0) chk("hold_stable", stable, 1);
            n_out   = out_q.size();
            m_ready = 1'b1;
            @(negedge clk);
            m_ready = 1'b0;
            chk("handshake", out_q.size(), n_out + 1);
            chk("ready_after_hs", s_tready, 1);
        end
    endtask

    initial begin
        int base;
        int nout;
        bit stale;
        // Reset state.
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tready", s_tready, 0);
        chk("rst_tvalid", m_valid, 0);
        chk("rst_phase", m_phase, 0);
`ifdef DDS_ATAN_MAG_EN
        chk("rst_mag", m_mag, 0);
`endif
        reset_n = 1'b1;
        #1 chk("tready_low_after_release", s_tready, 0);
        @(posedge clk);
        #1 chk("tready_rise", s_tready, 1);

        // Cardinal points and diagonals.
        drive_accept(0, 32767);       collect(0,     2, 53960, 6, 0, 1);
        drive_accept(32767, 0);       collect(16384, 2, 53960, 6, 0, 1);
        drive_accept(0, -32768);      collect(32768, 2, 53962, 6, 0, 1);
        drive_accept(-32768, 0);      collect(49152, 2, 53962, 6, 0, 1);
        drive_accept(23170, 23170);   collect(8192,  2, model_mag(23170, 23170), 6, 0, 1);
        drive_accept(-23170, 23170);  collect(57344, 2, model_mag(-23170, 23170), 6, 0, 1);

        // Zero input.
        drive_accept(0, 0);           collect(0, 0, 0, 0, 0, 1);

        // Backpressure with the next sample pending upstream.
        base = acc_q.size();
        drive_accept(12000, -20000);
        @(negedge clk);
        s_tdata  = {16'(-5000), 16'(9000)};
        s_tvalid = 1'b1;
        collect(model_phase(12000, -20000), 2, model_mag(12000, -20000), 6, 20, 1);
        chk("no_early_accept", acc_q.size(), base + 1);
        wait_acc(base + 2);
        s_tvalid = 1'b0;
        if (acc_q.size() >= base + 2) chk("accept_after_hs", acc_q[base + 1] - out_cyc_q[$], 1);
        collect(model_phase(-5000, 9000), 2, model_mag(-5000, 9000), 6, 0, 1);

        // Back-to-back with the consumer always ready: minimum interval.
        base = acc_q.size();
        nout = out_q.size();
        m_ready = 1'b1;
        @(negedge clk);
        s_tdata  = {16'(20000), 16'(-15000)};
        s_tvalid = 1'b1;
        wait_acc(base + 1);
        s_tdata = {16'(-30000), 16'(-6000)};
        wait_acc(base + 2);
        s_tvalid = 1'b0;
        if (acc_q.size() >= base + 2) chk("min_interval", acc_q[base + 1] - acc_q[base], ITERATIONS + 2);
        for (int k = 0; k < 40 && out_q.size() < nout + 2; k++) @(negedge clk);
        m_ready = 1'b0;
        chk("b2b_results", out_q.size(), nout + 2);
        if (out_q.size() >= nout + 2) begin
            chk_tol("b2b_phase0", out_q[nout], model_phase(20000, -15000), 2);
            chk_tol("b2b_phase1", out_q[nout + 1], model_phase(-30000, -6000), 2);
        end

        // Reset pulse at iteration 5 of ROTATE.
        nout = out_q.size();
        drive_accept(10000, 25000);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("abort_tvalid", m_valid, 0);
        chk("abort_tdata", m_phase, 0);
        chk("abort_tready", s_tready, 0);
`ifdef DDS_ATAN_MAG_EN
        chk("abort_mag", m_mag, 0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        #1 chk("abort_tready_release", s_tready, 0);
        @(posedge clk);
        #1 chk("abort_tready_rise", s_tready, 1);
        m_ready = 1'b1;
        stale = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (m_valid !== 1'b0) stale = 1'b1;
        end
        m_ready = 1'b0;
        chk("no_stale_result", stale, 0);
        chk("no_stale_handshake", out_q.size(), nout);

        // Random samples with amplitude >= 2^14 and random consumer stalls.
        for (int v = 0; v < 40; v++) begin
            logic signed [15:0] t16;
            int rs;
            int rc;
            rs = 16384;
            rc = 0;
            for (int tries = 0; tries < 100; tries++) begin
                t16 = 16'($urandom);
                rs  = t16;
                t16 = 16'($urandom);
                rc  = t16;
                if (real'(rs) * real'(rs) + real'(rc) * real'(rc) >= 268435456.0) break;
            end
            drive_accept(rs, rc);
            collect(model_phase(rs, rc), 3, model_mag(rs, rc), 6, $urandom_range(0, 3), 1);
        end

        // DDS loopback sweep: full-scale sin/cos of phase p, steps of 257.
        for (int p = 0; p < 65536; p += 257) begin
            real th;
            int  s;
            int  c;
            th = 2.0 * PI * real'(p) / 65536.0;
            s  = rnd(32767.0 * $sin(th));
            c  = rnd(32767.0 * $cos(th));
            drive_accept(s, c);
            collect(p, 3, 53958, 4, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cordic_atan2.md
# cordic_atan2

Iterative CORDIC vectoring engine that performs the inverse of the DDS. It takes a signed sin/cos sample pair and returns its unsigned phase, using the same phase scaling the DDS consumes: 0..2^PHASE_DW-1 maps to 0..2π. It sits downstream of a DDS or mixer, for phase recovery, loopback self-test and PLL phase detection. Both sides use AXI-stream handshakes with backpressure, so the block can stall an upstream source.

## Interface
- IN_DW, 16: width of each signed input component.
- PHASE_DW, 16: width of the output phase, in the same format as the DDS phase input.
- ITERATIONS, 14: number of CORDIC micro-rotations. Legal range is 4..PHASE_DW.
- clk  in  1  single clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- s_axis_in_tdata  in  2*IN_DW  packed as {sin, cos}: sin in the upper half, cos in the lower half, same packing as the DDS m_axis_out_tdata; both signed.
- s_axis_in_tvalid  in  1  input valid.
- s_axis_in_tready  out  1  input ready.
- m_axis_phase_tdata  out  PHASE_DW  unsigned phase result.
- m_axis_phase_tvalid  out  1  result valid.
- m_axis_phase_tready  in  1  downstream ready.
- m_axis_mag_tdata  out  IN_DW+2  unsigned CORDIC magnitude. This port exists only when DDS_ATAN_MAG_EN is defined.

## Operation
- FSM states:
  - IDLE: s_axis_in_tready=1.
  - ROTATE: runs ITERATIONS cycles; an iteration counter counts 0..ITERATIONS-1.
  - DONE: m_axis_phase_tvalid=1; outputs are held stable until accepted.
- Transitions:
  - IDLE→ROTATE on s_axis_in_tvalid && s_axis_in_tready.
  - ROTATE→DONE when the counter reaches ITERATIONS-1.
  - DONE→IDLE on m_axis_phase_tready.
- Capture and pre-rotation, performed in the accept cycle:
  - x=cos and y=sin, each sign-extended to IN_DW+2 bits.
  - If x<0, negate both x and y and set z=2^(PHASE_DW-1); otherwise z=0.
  - Negating -2^(IN_DW-1) must not overflow; the 2 guard bits guarantee this.
- Iteration i: if y≥0, then x+=y>>>i, y-=x>>>i, z+=A[i]; else x-=y>>>i, y+=x>>>i, z-=A[i].
  - All right shifts are arithmetic.
  - x and y update simultaneously, using their pre-update values.
- A[i] is round(atan(2^-i)·2^PHASE_DW/(2π)), computed at elaboration with real math and stored as a PHASE_DW-bit constant.
- z is PHASE_DW bits wide and wraps modulo 2^PHASE_DW. Wrap is the intended behaviour: a negative angle in quadrant 4 yields values near 2^PHASE_DW.
- Zero input: if sin=0 and cos=0 at capture, a flag forces the output phase to 0 (and magnitude to 0).
- Accuracy: the phase error must be ≤2 LSB for input amplitude ≥2^(IN_DW-2) with ITERATIONS≥PHASE_DW-2.

## Timing
- Reset values:
  - s_axis_in_tready=0, m_axis_phase_tvalid=0, m_axis_phase_tdata=0, m_axis_mag_tdata=0, FSM=IDLE, counter=0.
  - s_axis_in_tready is registered and rises on the first clk edge after reset_n deasserts.
- Latency: the result is valid ITERATIONS+1 cycles after the accept edge.
- Minimum input interval is ITERATIONS+2 cycles, reached when m_axis_phase_tready is held high.
- s_axis_in_tready is 0 throughout ROTATE and DONE.
- m_axis_phase_tdata and m_axis_mag_tdata must not change while tvalid=1 and tready=0.
- In DONE with tready=1, the block returns to IDLE and s_axis_in_tready=1 on the next cycle. There is no combinational path from m_axis_phase_tready to s_axis_in_tready.
- Asserting reset_n low mid-ROTATE or mid-DONE immediately aborts: outputs return to their reset values and the in-flight sample is discarded.
- s_axis_in_tvalid during ROTATE/DONE is ignored, not lost: the upstream source holds its data until tready.

## Configuration
- DDS_ATAN_MAG_EN defined:
  - Adds the m_axis_mag_tdata port.
  - Carries the final x, which equals about 1.64676×amplitude (CORDIC gain is not compensated).
  - The value is registered into DONE alongside the phase and shares the m_axis_phase handshake.
- DDS_ATAN_MAG_EN undefined: the port and its register are absent, and phase behaviour is identical.

## Test plan
- Cardinal points: {0,32767}→0; {32767,0}→16384; {0,-32768}→32768; {-32768,0}→49152. Each result is within ±2 LSB and valid exactly 15 cycles after accept.
- Diagonals: {23170,23170}→8192; {-23170,23170}→57344, which exercises the z wrap through zero. Both within ±2 LSB.
- Zero input: {0,0}→phase 0 (and magnitude 0 with DDS_ATAN_MAG_EN).
- Backpressure: hold m_axis_phase_tready=0 for 20 cycles after valid. Output data stays stable, s_axis_in_tready stays 0, and the next sample is accepted only after the handshake.
- Reset mid-ROTATE: pulse reset_n low at iteration 5. tvalid=0 and tdata=0 immediately; tready rises 1 cycle after release; no stale result appears.
- DDS loopback: sweep the DDS phase (SIN_COS=1) in steps of 257 over a full cycle and feed the DDS output here. Recovered phase equals input phase within ±3 LSB, including the 0/65535 wrap. With DDS_ATAN_MAG_EN, magnitude is 53958±4.
